stream_sel_mux: RTL and testbench

- Parametrised N-to-1 selector with a registered output and valid/ready handshakes on every input and on the output.
- Next generation of the team's 2:1 combinational mux: generalises data width and input count, and adds a fixed-select / round-robin mode.
- Sits between multiple producers (e.g. register-file read ports, forwarding sources) and one consumer stage in the datapath.

---
 rtl/stream_sel_pkg.sv | 13 +
 rtl/stream_sel_mux_if.sv | 30 +++
 rtl/stream_sel_mux_rr_arbiter.sv | 71 +++++++
 rtl/stream_sel_mux.sv | 97 +++++++++
 tb/tb_stream_sel_mux.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/stream_sel_pkg.sv
// Shared constants for the stream_sel_mux N-to-1 selector.
package stream_sel_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;
   localparam int   CNT_W      = 16;

   // Select/source-ID width: $clog2(n), but never narrower than one bit.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/stream_sel_mux_if.sv
// Handshake bundle for stream_sel_mux: N producer channels, one consumer, mode/select controls.
interface stream_sel_mux_if #(
   parameter int WIDTH  = 2,
   parameter int NUM_IN = 2
);
   import stream_sel_pkg::*;

   localparam int SEL_W = sel_width(NUM_IN);

   logic                     rr_mode;
   logic [SEL_W-1:0]         sel;
   logic [NUM_IN*WIDTH-1:0]  in_data;
   logic [NUM_IN-1:0]        in_valid;
   logic [NUM_IN-1:0]        in_ready;
   logic [WIDTH-1:0]         out_data;
   logic [SEL_W-1:0]         out_src;
   logic                     out_valid;
   logic                     out_ready;

   modport master (
      output rr_mode, sel, in_data, in_valid, out_ready,
      input  in_ready, out_data, out_src, out_valid
   );

   modport slave (
      input  rr_mode, sel, in_data, in_valid, out_ready,
      output in_ready, out_data, out_src, out_valid
   );

endinterface

// File: rtl/stream_sel_mux_rr_arbiter.sv
// Grant logic for stream_sel_mux: fixed select or round-robin from a rotating pointer.
module rr_arbiter
   import stream_sel_pkg::*;
#(
   parameter  int NUM_IN = 2,
   localparam int SEL_W  = sel_width(NUM_IN)
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [SEL_W-1:0]  ptr,
   input  logic              rr_mode,
   input  logic [SEL_W-1:0]  sel,
   input  logic              adv,
   output logic [NUM_IN-1:0] grant,
   output logic [SEL_W-1:0]  grant_idx,
   output logic [SEL_W-1:0]  ptr_nxt
);

   logic [SEL_W:0]   cand_s;
   logic [SEL_W-1:0] cidx_s;
   logic             found_s;

   // Grant selection; the RR search starts at ptr and wraps modulo NUM_IN
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      cand_s    = '0;
      cidx_s    = '0;
      found_s   = 1'b0;
      if (rr_mode == MODE_RR) begin
         for (int k = 0; k < NUM_IN; k++) begin
            cand_s = {1'b0, ptr} + (SEL_W+1)'(k);
            if (cand_s >= (SEL_W+1)'(NUM_IN)) begin
               cand_s = cand_s - (SEL_W+1)'(NUM_IN);
            end else begin
               cand_s = cand_s;
            end
            cidx_s = cand_s[SEL_W-1:0];
            if (!found_s && req[cidx_s]) begin
               found_s       = 1'b1;
               grant[cidx_s] = 1'b1;
               grant_idx     = cidx_s;
            end else begin
               found_s = found_s;
            end
         end
      end else begin
         if (int'(sel) < NUM_IN) begin
            grant[sel] = req[sel];
            grant_idx  = sel;
         end else begin
            grant     = '0;
            grant_idx = '0;
         end
      end
   end

   // Pointer moves past the granted channel only on an RR transfer
   always_comb begin
      ptr_nxt = ptr;
      if (adv && (rr_mode == MODE_RR)) begin
         if (int'(grant_idx) == NUM_IN - 1) begin
            ptr_nxt = '0;
         end else begin
            ptr_nxt = grant_idx + SEL_W'(1);
         end
      end else begin
         ptr_nxt = ptr;
      end
   end

endmodule

// File: rtl/stream_sel_mux.sv
// N-to-1 stream selector with registered output; optional transfer counter under STREAM_SEL_MUX_CNT_EN.
module stream_sel_mux
   import stream_sel_pkg::*;
#(
   parameter int WIDTH  = 2,
   parameter int NUM_IN = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   stream_sel_mux_if.slave   bus
`ifdef STREAM_SEL_MUX_CNT_EN
   ,
   output logic [CNT_W-1:0]  xfer_cnt
`endif
);

   localparam int SEL_W = sel_width(NUM_IN);

   logic [NUM_IN-1:0] grant_s;
   logic [SEL_W-1:0]  grant_idx_s;
   logic [SEL_W-1:0]  ptr_nxt_s;
   logic [SEL_W-1:0]  ptr_r;
   logic [WIDTH-1:0]  sel_data_s;
   logic              can_load_s;
   logic              load_s;
   logic              drain_s;
   logic [WIDTH-1:0]  out_data_r;
   logic [SEL_W-1:0]  out_src_r;
   logic              out_valid_r;

   rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
      .req       (bus.in_valid),
      .ptr       (ptr_r),
      .rr_mode   (bus.rr_mode),
      .sel       (bus.sel),
      .adv       (load_s),
      .grant     (grant_s),
      .grant_idx (grant_idx_s),
      .ptr_nxt   (ptr_nxt_s)
   );

   assign can_load_s   = !out_valid_r | bus.out_ready;
   assign load_s       = rst_n & can_load_s & (|grant_s);
   assign drain_s      = out_valid_r & bus.out_ready;
   assign bus.in_ready = grant_s & {NUM_IN{can_load_s & rst_n}};

   // AND-OR data mux; grant is one-hot or zero
   always_comb begin
      sel_data_s = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         sel_data_s = sel_data_s | (bus.in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_s[i]}});
      end
   end

   // Output register and RR pointer; a load in a draining cycle keeps out_valid high
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_data_r  <= '0;
         out_src_r   <= '0;
         out_valid_r <= 1'b0;
         ptr_r       <= '0;
      end else begin
         ptr_r <= ptr_nxt_s;
         if (load_s) begin
            out_data_r  <= sel_data_s;
            out_src_r   <= grant_idx_s;
            out_valid_r <= 1'b1;
         end else if (drain_s) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
      end
   end

   assign bus.out_data  = out_data_r;
   assign bus.out_src   = out_src_r;
   assign bus.out_valid = out_valid_r;

`ifdef STREAM_SEL_MUX_CNT_EN
   logic [CNT_W-1:0] cnt_r;

   // Saturating count of output transfers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r <= '0;
      end else if (drain_s && (cnt_r != {CNT_W{1'b1}})) begin
         cnt_r <= cnt_r + CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign xfer_cnt = cnt_r;
`endif

endmodule

// File: tb/tb_stream_sel_mux.sv
// Directed self-checking bench for stream_sel_mux (NUM_IN=4 and NUM_IN=6, WIDTH=8).
module tb_stream_sel_mux;
   import stream_sel_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   stream_sel_mux_if #(.WIDTH(8), .NUM_IN(4)) if4 ();
   stream_sel_mux_if #(.WIDTH(8), .NUM_IN(6)) if6 ();

`ifdef STREAM_SEL_MUX_CNT_EN
   logic [CNT_W-1:0] cnt4;
   logic [CNT_W-1:0] cnt6;
`endif

   stream_sel_mux #(.WIDTH(8), .NUM_IN(4)) u_dut4 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (if4.slave)
`ifdef STREAM_SEL_MUX_CNT_EN
      ,
      .xfer_cnt (cnt4)
`endif
   );

   stream_sel_mux #(.WIDTH(8), .NUM_IN(6)) u_dut6 (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (if6.slave)
`ifdef STREAM_SEL_MUX_CNT_EN
      ,
      .xfer_cnt (cnt6)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      if4.rr_mode = MODE_FIXED; if4.sel = 2'd0; if4.out_ready = 1'b1;
      if4.in_valid = 4'hF; if4.in_data = 32'h44332211;
      if6.rr_mode = MODE_FIXED; if6.sel = 3'd0; if6.out_ready = 1'b1;
      if6.in_valid = 6'h3F; if6.in_data = 48'h656463626160;
      step(); step(); mid();
      n_checks++; if (if4.in_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_in_ready4: got %b exp 0000", if4.in_ready); end
      n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid4: got %b exp 0", if4.out_valid); end
      n_checks++; if (if4.out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data4: got %h exp 00", if4.out_data); end
      n_checks++; if (if4.out_src !== 2'd0) begin n_fail++; $display("FAIL rst_out_src4: got %0d exp 0", if4.out_src); end
      n_checks++; if (if6.in_ready !== 6'b000000) begin n_fail++; $display("FAIL rst_in_ready6: got %b exp 000000", if6.in_ready); end
      step();
      rst_n = 1'b1; if6.in_valid = 6'h00;
      mid();
      n_checks++; if (if4.in_ready !== 4'b0001) begin n_fail++; $display("FAIL rel_in_ready: got %b exp 0001", if4.in_ready); end
      n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_early_valid: got %b exp 0", if4.out_valid); end
      step();
      n_checks++; if (if4.out_valid !== 1'b1) begin n_fail++; $display("FAIL rel_valid: got %b exp 1", if4.out_valid); end
      n_checks++; if (if4.out_data !== 8'h11) begin n_fail++; $display("FAIL rel_data: got %h exp 11", if4.out_data); end
      if4.in_valid = 4'h0;
      step();
      n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL rel_drain: got %b exp 0", if4.out_valid); end
   endtask

   task automatic test_fixed();
      if4.sel = 2'd2; if4.in_valid = 4'b0100; if4.in_data = 32'h00A50000;
      mid();
      n_checks++; if (if4.in_ready !== 4'b0100) begin n_fail++; $display("FAIL fix_in_ready: got %b exp 0100", if4.in_ready); end
      step();
      n_checks++; if (if4.out_data !== 8'hA5) begin n_fail++; $display("FAIL fix_data: got %h exp a5", if4.out_data); end
      n_checks++; if (if4.out_src !== 2'd2) begin n_fail++; $display("FAIL fix_src: got %0d exp 2", if4.out_src); end
      if4.sel = 2'd3; if4.in_valid = 4'b1100; if4.in_data = 32'h3CA50000;
      mid();
      n_checks++; if (if4.in_ready !== 4'b1000) begin n_fail++; $display("FAIL fix_sel3_ready: got %b exp 1000", if4.in_ready); end
      step();
      n_checks++; if (if4.out_data !== 8'h3C || if4.out_src !== 2'd3) begin n_fail++; $display("FAIL fix_sel3_out: got %h/%0d exp 3c/3", if4.out_data, if4.out_src); end
      if4.in_valid = 4'h0;
      step();
   endtask

   task automatic test_sel_range();
      logic [2:0] sels [3];
      logic [5:0] vals [3];
      sels = '{3'd5, 3'd6, 3'd7};
      vals = '{6'b011111, 6'b111111, 6'b111111};
      for (int i = 0; i < 3; i++) begin
         if6.sel = sels[i]; if6.in_valid = vals[i];
         mid();
         n_checks++; if (if6.in_ready !== 6'b000000) begin n_fail++; $display("FAIL range_ready sel=%0d: got %b exp 000000", sels[i], if6.in_ready); end
         step();
         n_checks++; if (if6.out_valid !== 1'b0) begin n_fail++; $display("FAIL range_valid sel=%0d: got %b exp 0", sels[i], if6.out_valid); end
      end
      if6.sel = 3'd5; if6.in_valid = 6'h3F;
      mid();
      n_checks++; if (if6.in_ready !== 6'b100000) begin n_fail++; $display("FAIL sel5_ready: got %b exp 100000", if6.in_ready); end
      step();
      n_checks++; if (if6.out_src !== 3'd5 || if6.out_data !== 8'h65) begin n_fail++; $display("FAIL sel5_out: got %0d/%h exp 5/65", if6.out_src, if6.out_data); end
      if6.in_valid = 6'h00;
      step();
   endtask

   task automatic test_rr_fairness();
      logic [3:0] exp_rdy;
      logic [1:0] exp_src;
      if4.rr_mode = MODE_RR; if4.in_data = 32'h13121110; if4.in_valid = 4'hF;
      for (int k = 0; k < 5; k++) begin
         exp_src = 2'(k % 4);
         exp_rdy = 4'b0001 << exp_src;
         mid();
         n_checks++; if (if4.in_ready !== exp_rdy) begin n_fail++; $display("FAIL rr_ready beat%0d: got %b exp %b", k, if4.in_ready, exp_rdy); end
         step();
         n_checks++; if (if4.out_src !== exp_src || if4.out_data !== (8'h10 + 8'(exp_src)) || if4.out_valid !== 1'b1)
            begin n_fail++; $display("FAIL rr_out beat%0d: got src %0d data %h v %b exp src %0d", k, if4.out_src, if4.out_data, if4.out_valid, exp_src); end
      end
      if4.in_valid = 4'h0;
      step();
   endtask

   task automatic test_rr_skip_wrap();
      logic [1:0] exp_seq [4];
      logic [3:0] exp_rdy;
      exp_seq = '{2'd3, 2'd1, 2'd3, 2'd1};
      if4.in_valid = 4'b0010;
      step();
      n_checks++; if (if4.out_src !== 2'd1) begin n_fail++; $display("FAIL skip_setup: got %0d exp 1", if4.out_src); end
      if4.in_valid = 4'b1010;
      for (int k = 0; k < 4; k++) begin
         exp_rdy = 4'b0001 << exp_seq[k];
         mid();
         n_checks++; if (if4.in_ready !== exp_rdy) begin n_fail++; $display("FAIL skip_ready beat%0d: got %b exp %b", k, if4.in_ready, exp_rdy); end
         step();
         n_checks++; if (if4.out_src !== exp_seq[k]) begin n_fail++; $display("FAIL skip_src beat%0d: got %0d exp %0d", k, if4.out_src, exp_seq[k]); end
      end
      if4.in_valid = 4'h0;
      step();
   endtask

   task automatic test_backpressure();
      if4.rr_mode = MODE_FIXED; if4.sel = 2'd1; if4.in_valid = 4'b0010; if4.in_data = 32'h0000B100;
      step();
      if4.in_data = 32'h0000B200; if4.out_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         mid();
         n_checks++; if (if4.in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready cyc%0d: got %b exp 0000", k, if4.in_ready); end
         step();
         n_checks++; if (if4.out_data !== 8'hB1 || if4.out_src !== 2'd1 || if4.out_valid !== 1'b1)
            begin n_fail++; $display("FAIL bp_hold cyc%0d: got %h/%0d/%b exp b1/1/1", k, if4.out_data, if4.out_src, if4.out_valid); end
      end
      if4.out_ready = 1'b1;
      mid();
      n_checks++; if (if4.in_ready !== 4'b0010) begin n_fail++; $display("FAIL bp_release_ready: got %b exp 0010", if4.in_ready); end
      step();
      n_checks++; if (if4.out_valid !== 1'b1 || if4.out_data !== 8'hB2) begin n_fail++; $display("FAIL bp_drain_load: got %b/%h exp 1/b2", if4.out_valid, if4.out_data); end
      if4.in_valid = 4'h0;
      step();
      n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got %b exp 0", if4.out_valid); end
   endtask

   task automatic test_mode_switch();
      if4.sel = 2'd0; if4.in_valid = 4'b0001; if4.in_data = 32'h000000C0;
      step();
      if4.out_ready = 1'b0; if4.rr_mode = MODE_RR; if4.in_valid = 4'hF; if4.in_data = 32'h13121110;
      mid();
      n_checks++; if (if4.in_ready !== 4'b0000) begin n_fail++; $display("FAIL sw_ready_held: got %b exp 0000", if4.in_ready); end
      step();
      n_checks++; if (if4.out_data !== 8'hC0 || if4.out_src !== 2'd0) begin n_fail++; $display("FAIL sw_held: got %h/%0d exp c0/0", if4.out_data, if4.out_src); end
      if4.out_ready = 1'b1;
      mid();
      n_checks++; if (if4.in_ready !== 4'b0100) begin n_fail++; $display("FAIL sw_ptr_kept: got %b exp 0100", if4.in_ready); end
      step();
      n_checks++; if (if4.out_src !== 2'd2 || if4.out_data !== 8'h12) begin n_fail++; $display("FAIL sw_rr_out: got %0d/%h exp 2/12", if4.out_src, if4.out_data); end
      if4.in_valid = 4'h0;
      step();
   endtask

   task automatic test_counter_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
`ifdef STREAM_SEL_MUX_CNT_EN
      n_checks++; if (cnt4 !== 16'd0) begin n_fail++; $display("FAIL cnt_clear: got %0d exp 0", cnt4); end
`endif
      if4.rr_mode = MODE_RR; if4.in_valid = 4'hF;
      repeat (10) step();
      if4.in_valid = 4'h0;
      step();
      n_checks++; if (if4.out_valid !== 1'b0) begin n_fail++; $display("FAIL cnt_run_empty: got %b exp 0", if4.out_valid); end
`ifdef STREAM_SEL_MUX_CNT_EN
      n_checks++; if (cnt4 !== 16'd10) begin n_fail++; $display("FAIL cnt_ten: got %0d exp 10", cnt4); end
`endif
      if4.in_valid = 4'hF;
      step(); step(); step();
      rst_n = 1'b0;
      mid();
      n_checks++; if (if4.in_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_ready: got %b exp 0000", if4.in_ready); end
      step();
      n_checks++; if (if4.out_valid !== 1'b0 || if4.out_data !== 8'h00) begin n_fail++; $display("FAIL mid_rst_out: got %b/%h exp 0/00", if4.out_valid, if4.out_data); end
`ifdef STREAM_SEL_MUX_CNT_EN
      n_checks++; if (cnt4 !== 16'd0) begin n_fail++; $display("FAIL mid_rst_cnt: got %0d exp 0", cnt4); end
`endif
      rst_n = 1'b1; if4.in_valid = 4'h0;
      step();
   endtask

   initial begin
      test_reset();
      test_fixed();
      test_sel_range();
      test_rr_fairness();
      test_rr_skip_wrap();
      test_backpressure();
      test_mode_switch();
      test_counter_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
